// File: rtl/msdap_pkg.sv
// Shared types and constants for the MSDAP convolution sequencer and its op pipe.
package msdap_pkg;

    localparam int NUM_RJ_DEF    = 16;
    localparam int COEF_AW_DEF   = 9;
    localparam int DATA_AW_DEF   = 8;
    localparam int RJ_AW         = 4;
    localparam int RJ_CNT_W      = 10;
    localparam int SS_W          = 9;
    localparam int COEF_SIGN_BIT = 8;

    localparam logic [SS_W-1:0] SS_MAX = 9'd256;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RJ_ADDR = 3'd1,
        S_RJ_LAT  = 3'd2,
        S_COEF    = 3'd3,
        S_DRAIN   = 3'd4,
        S_SHIFT   = 3'd5,
        S_DONE    = 3'd6
    } seq_state_e;

endpackage

// File: rtl/msdap_op_pipe.sv
// Two-stage coefficient pipe: data address one cycle after the coefficient read, ALU op two cycles after.
// MSDAP_SEQ_ZERO_FILL_EN enables data_zero for delays reaching past the samples seen so far.
module msdap_op_pipe
    import msdap_pkg::*;
#(
    parameter int DATA_AW = DATA_AW_DEF
) (
    input  logic               sclk,
    input  logic               reset,
    input  logic               clear,
    input  logic               issue,
    input  logic [15:0]        coef_rd_data,
    input  logic [DATA_AW-1:0] base,
    input  logic [SS_W-1:0]    samples_seen,
    output logic [DATA_AW-1:0] data_rd_addr,
    output logic [1:0]         alu_op,
    output logic               data_zero
);

    logic       v1;
    logic [7:0] n;
    logic       sign;
    logic       unused_bits;

    assign n    = coef_rd_data[7:0];
    assign sign = coef_rd_data[COEF_SIGN_BIT];

    // Coefficient RAM output is itself a register, so the address is one subtract past a flop.
    assign data_rd_addr = v1 ? (base - DATA_AW'(n)) : '0;

    always_ff @(posedge sclk) begin
        if (reset || clear) begin
            v1     <= 1'b0;
            alu_op <= OP_NOP;
        end else begin
            v1     <= issue;
            alu_op <= !v1 ? OP_NOP : (sign ? OP_SUB : OP_ADD);
        end
    end

`ifdef MSDAP_SEQ_ZERO_FILL_EN
    always_ff @(posedge sclk) begin
        if (reset || clear) begin
            data_zero <= 1'b0;
        end else begin
            data_zero <= v1 && ({1'b0, n} >= samples_seen);
        end
    end
    assign unused_bits = ^coef_rd_data[15:9];
`else
    assign data_zero   = 1'b0;
    assign unused_bits = ^{coef_rd_data[15:9], samples_seen};
`endif

endmodule

// File: rtl/msdap_conv_sequencer.sv
// Per-channel convolution sequencer: walks Rj groups and coefficients, drives the accumulator ALU.
// MSDAP_SEQ_ZERO_FILL_EN adds the samples_seen counter behind data_zero.
module msdap_conv_sequencer
    import msdap_pkg::*;
#(
    parameter int NUM_RJ  = NUM_RJ_DEF,
    parameter int COEF_AW = COEF_AW_DEF,
    parameter int DATA_AW = DATA_AW_DEF
) (
    input  logic               sclk,
    input  logic               reset,
    input  logic               clear,
    input  logic               sample_valid,
    input  logic [DATA_AW-1:0] sample_ptr,
    output logic [RJ_AW-1:0]   rj_rd_addr,
    input  logic [15:0]        rj_rd_data,
    output logic [COEF_AW-1:0] coef_rd_addr,
    input  logic [15:0]        coef_rd_data,
    output logic [DATA_AW-1:0] data_rd_addr,
    output logic [1:0]         alu_op,
    output logic               data_zero,
    output logic               alu_clr,
    output logic               alu_shift,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun,
    output logic               cfg_err,
    output logic [2:0]         dbg_state
);

    localparam logic [RJ_AW-1:0] LAST_GROUP = RJ_AW'(NUM_RJ - 1);

    seq_state_e          state;
    logic [DATA_AW-1:0]  base;
    logic [RJ_AW-1:0]    group;
    logic [COEF_AW:0]    coef_ptr;
    logic [RJ_CNT_W-1:0] rem;
    logic [RJ_CNT_W-1:0] rj_cnt;
    logic                drain_cnt;
    logic                coef_issue;
    logic                issue_now;
    logic [SS_W-1:0]     samples_seen;
    logic                unused_rj;

    assign rj_cnt    = rj_rd_data[RJ_CNT_W-1:0];
    assign unused_rj = ^rj_rd_data[15:RJ_CNT_W];
    assign dbg_state = state;

    // Outputs are registered for the state being entered, so each COEF cycle is set up one cycle early.
    assign issue_now = ((state == S_RJ_LAT) && (rj_cnt != '0)) ||
                       ((state == S_COEF) && (rem != '0));

    always_ff @(posedge sclk) begin
        if (reset) begin
            state        <= S_IDLE;
            base         <= '0;
            group        <= '0;
            coef_ptr     <= '0;
            rem          <= '0;
            drain_cnt    <= 1'b0;
            coef_issue   <= 1'b0;
            coef_rd_addr <= '0;
            rj_rd_addr   <= '0;
            alu_clr      <= 1'b0;
            alu_shift    <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            coef_issue   <= 1'b0;
            coef_rd_addr <= '0;
            rj_rd_addr   <= '0;
            alu_clr      <= 1'b0;
            alu_shift    <= 1'b0;
            out_valid    <= 1'b0;
            if (sample_valid && !clear && (state != S_IDLE)) overrun <= 1'b1;
            if (clear) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                // Once the 512 coefficients are used up, COEF cycles still elapse but issue nothing.
                if (issue_now) begin
                    if (coef_ptr[COEF_AW]) begin
                        cfg_err <= 1'b1;
                    end else begin
                        coef_issue   <= 1'b1;
                        coef_rd_addr <= coef_ptr[COEF_AW-1:0];
                        coef_ptr     <= coef_ptr + 1'b1;
                    end
                end
                case (state)
                    S_IDLE: if (sample_valid) begin
                        state    <= S_RJ_ADDR;
                        base     <= sample_ptr;
                        group    <= '0;
                        coef_ptr <= '0;
                        alu_clr  <= 1'b1;
                        busy     <= 1'b1;
                    end
                    S_RJ_ADDR: state <= S_RJ_LAT;
                    S_RJ_LAT: begin
                        drain_cnt <= 1'b0;
                        if (rj_cnt == '0) begin
                            state <= S_DRAIN;
                        end else begin
                            rem   <= rj_cnt - 1'b1;
                            state <= S_COEF;
                        end
                    end
                    S_COEF: begin
                        if (rem == '0) begin
                            state     <= S_DRAIN;
                            drain_cnt <= 1'b0;
                        end else begin
                            rem <= rem - 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt) begin
                            state      <= S_SHIFT;
                            alu_shift  <= 1'b1;
                            rj_rd_addr <= group + 1'b1;
                        end else begin
                            drain_cnt <= 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (group == LAST_GROUP) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            group <= group + 1'b1;
                            state <= S_RJ_LAT;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef MSDAP_SEQ_ZERO_FILL_EN
    always_ff @(posedge sclk) begin
        if (reset || clear) begin
            samples_seen <= '0;
        end else if (sample_valid && (samples_seen != SS_MAX)) begin
            samples_seen <= samples_seen + 1'b1;
        end
    end
`else
    assign samples_seen = '0;
`endif

    msdap_op_pipe #(.DATA_AW(DATA_AW)) u_op_pipe (
        .sclk         (sclk),
        .reset        (reset),
        .clear        (clear),
        .issue        (coef_issue),
        .coef_rd_data (coef_rd_data),
        .base         (base),
        .samples_seen (samples_seen),
        .data_rd_addr (data_rd_addr),
        .alu_op       (alu_op),
        .data_zero    (data_zero)
    );

endmodule

// File: tb/tb_msdap_conv_sequencer.sv
// Self-checking bench: a frame-level schedule model predicts every output per cycle.
`timescale 1ns/1ps
module tb_msdap_conv_sequencer;

    localparam int MAXC = 40000;
`ifdef MSDAP_SEQ_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic sclk = 1'b0, reset = 1'b1, clear = 1'b0, sample_valid = 1'b0;
    logic [7:0] sample_ptr = 8'h00;
    logic [3:0] rj_rd_addr;
    logic [15:0] rj_rd_data, coef_rd_data;
    logic [8:0] coef_rd_addr;
    logic [7:0] data_rd_addr;
    logic [1:0] alu_op;
    logic data_zero, alu_clr, alu_shift, out_valid, busy, overrun, cfg_err;
    logic [2:0] dbg_state;

    msdap_conv_sequencer dut (
        .sclk(sclk), .reset(reset), .clear(clear), .sample_valid(sample_valid),
        .sample_ptr(sample_ptr), .rj_rd_addr(rj_rd_addr), .rj_rd_data(rj_rd_data),
        .coef_rd_addr(coef_rd_addr), .coef_rd_data(coef_rd_data),
        .data_rd_addr(data_rd_addr), .alu_op(alu_op), .data_zero(data_zero),
        .alu_clr(alu_clr), .alu_shift(alu_shift), .out_valid(out_valid),
        .busy(busy), .overrun(overrun), .cfg_err(cfg_err), .dbg_state(dbg_state)
    );

    // clock / memories
    always #5 sclk = ~sclk;

    logic [15:0] rj_mem[16];
    logic [15:0] coef_mem[512];
    always @(posedge sclk) begin
        rj_rd_data   <= rj_mem[rj_rd_addr];
        coef_rd_data <= coef_mem[coef_rd_addr];
    end

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    // expected per-cycle outputs
    bit       e_clr[MAXC], e_shift[MAXC], e_ov[MAXC], e_busy[MAXC], e_dz[MAXC];
    bit [3:0] e_rj[MAXC];
    bit [8:0] e_caddr[MAXC];
    bit [7:0] e_daddr[MAXC];
    bit [1:0] e_op[MAXC];

    int ss_model = 0;
    int cfg_from = MAXC + 10;
    int over_from = MAXC + 10;
    bit chk_en = 1'b0;
    int c0 = 0;
    int n_cmp = 0, n_err = 0;

    int shift_cnt, op_cnt, ov_cnt, ov_cyc, clr_cyc;
    logic [1:0] op_q[$];
    bit dz_q[$];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Schedule: group g starts at s_g, its R coefficient reads follow, 2 drain cycles, then a shift.
    function automatic int build_frame(int f0, bit [7:0] b);
        int s, idx, r, tc, sh;
        bit [7:0] n;
        e_clr[f0+1] = 1'b1;
        s = f0 + 2;
        idx = 0;
        for (int g = 0; g < 16; g++) begin
            r = int'(rj_mem[g][9:0]);
            for (int k = 0; k < r; k++) begin
                tc = s + 1 + k;
                if (idx < 512) begin
                    e_caddr[tc]   = idx[8:0];
                    n             = coef_mem[idx][7:0];
                    e_daddr[tc+1] = b - n;
                    e_op[tc+2]    = coef_mem[idx][8] ? 2'd2 : 2'd1;
                    e_dz[tc+2]    = ZF && (int'(n) >= ss_model);
                    idx++;
                end else if (tc < cfg_from) begin
                    cfg_from = tc;
                end
            end
            sh = s + r + 3;
            e_shift[sh] = 1'b1;
            e_rj[sh]    = 4'((g + 1) % 16);
            s += r + 4;
        end
        e_ov[s] = 1'b1;
        for (int t = f0 + 1; t <= s; t++) e_busy[t] = 1'b1;
        return s - f0;
    endfunction

    function automatic void erase(int from, int to);
        for (int t = from; t <= to + 2; t++) begin
            e_clr[t] = 0; e_shift[t] = 0; e_ov[t] = 0; e_busy[t] = 0; e_dz[t] = 0;
            e_rj[t] = 0; e_caddr[t] = 0; e_daddr[t] = 0; e_op[t] = 0;
        end
    endfunction

    // scoreboard compare, every cycle
    always @(negedge sclk) begin
        if (chk_en && cyc < MAXC) begin
            check("alu_clr", alu_clr, e_clr[cyc]);
            check("alu_shift", alu_shift, e_shift[cyc]);
            check("out_valid", out_valid, e_ov[cyc]);
            check("busy", busy, e_busy[cyc]);
            check("rj_rd_addr", rj_rd_addr, e_rj[cyc]);
            check("coef_rd_addr", coef_rd_addr, e_caddr[cyc]);
            check("data_rd_addr", data_rd_addr, e_daddr[cyc]);
            check("alu_op", alu_op, e_op[cyc]);
            check("data_zero", data_zero, e_dz[cyc]);
            check("overrun", overrun, cyc >= over_from);
            check("cfg_err", cfg_err, cyc >= cfg_from);
            if (alu_shift) shift_cnt++;
            if (alu_clr) clr_cyc = cyc;
            if (alu_op != 2'b00) begin
                op_cnt++;
                op_q.push_back(alu_op);
                dz_q.push_back(data_zero);
            end
            if (out_valid) begin
                ov_cnt++;
                ov_cyc = cyc;
            end
        end
    end

    // driver tasks
    task automatic start_frame(bit [7:0] b, output int len);
        @(negedge sclk);
        sample_valid = 1'b1;
        sample_ptr = b;
        c0 = cyc;
        ss_model = (ss_model < 256) ? ss_model + 1 : 256;
        shift_cnt = 0; op_cnt = 0; ov_cnt = 0; ov_cyc = -1; clr_cyc = -1;
        op_q.delete();
        dz_q.delete();
        len = build_frame(c0, b);
        @(negedge sclk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_rel(int n);
        int k = 0;
        while (cyc < c0 + n && k < 5000) begin
            @(negedge sclk);
            k++;
        end
    endtask

    task automatic wait_done(int budget);
        int k = 0;
        while (ov_cnt == 0 && k < budget) begin
            @(negedge sclk);
            k++;
        end
        check("frame_done_in_budget", ov_cnt != 0, 1);
        @(negedge sclk);
    endtask

    task automatic set_rj_all(int r);
        for (int g = 0; g < 16; g++) rj_mem[g] = 16'(r);
    endtask

    initial begin
        int len;
        int bad;
        set_rj_all(0);
        for (int i = 0; i < 512; i++) coef_mem[i] = 16'h0000;

        repeat (3) @(negedge sclk);
        check("reset_busy", busy, 0);
        check("reset_alu_op", alu_op, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_flags", {overrun, cfg_err}, 0);
        check("reset_state", dbg_state, 0);
        reset = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge sclk);

        // first sample after reset: n=0 then n=1
        rj_mem[0] = 16'd2;
        coef_mem[0] = 16'h0000;
        coef_mem[1] = 16'h0101;
        start_frame(8'h37, len);
        wait_done(200);
        check("first_ops", op_cnt, 2);
        if (op_q.size() >= 2) begin
            check("first_op0", op_q[0], 2'd1);
            check("first_op1", op_q[1], 2'd2);
            check("first_dz0", dz_q[0], 0);
            check("first_dz1", dz_q[1], ZF);
        end
        check("first_ov_cycle", ov_cyc - c0, 68);

        // all Rj zero
        set_rj_all(0);
        start_frame(8'h80, len);
        wait_done(200);
        check("zero_clr_cycle", clr_cyc - c0, 1);
        check("zero_shifts", shift_cnt, 16);
        check("zero_ops", op_cnt, 0);
        check("zero_ov_cycle", ov_cyc - c0, 66);

        // bring samples seen to 300
        for (int f = 0; f < 298; f++) begin
            start_frame(8'($urandom), len);
            wait_done(200);
        end

        // full 512-coefficient frame
        set_rj_all(32);
        for (int i = 0; i < 512; i++) coef_mem[i] = {7'd0, i[0], i[7:0]};
        start_frame(8'h10, len);
        wait_rel(40);
        check("wrap_addr_coef20", data_rd_addr, 8'hF0);
        wait_done(1000);
        check("full_ops", op_cnt, 512);
        bad = 0;
        for (int k = 0; k < op_q.size(); k++) begin
            if (op_q[k] != ((k % 2) ? 2'd2 : 2'd1)) bad++;
            if (dz_q[k]) bad++;
        end
        check("full_alternation", bad, 0);
        check("full_shifts", shift_cnt, 16);
        check("full_ov_cycle", ov_cyc - c0, 578);

        // random frames, sum of Rj stays below 512
        for (int f = 0; f < 4; f++) begin
            for (int g = 0; g < 16; g++) rj_mem[g] = {6'($urandom), 10'($urandom_range(0, 31))};
            for (int i = 0; i < 512; i++) coef_mem[i] = 16'($urandom);
            start_frame(8'($urandom), len);
            wait_done(1000);
            check("rand_shifts", shift_cnt, 16);
        end

        // coefficient overflow: sum of Rj = 520
        set_rj_all(32);
        rj_mem[15] = 16'd40;
        start_frame(8'h55, len);
        wait_done(1000);
        check("cfg_err_set", cfg_err, 1);
        check("cfg_ops", op_cnt, 512);
        check("cfg_shifts", shift_cnt, 16);
        check("cfg_ov_cycle", ov_cyc - c0, 586);

        // sample during a frame
        set_rj_all(8);
        start_frame(8'h22, len);
        wait_rel(100);
        sample_valid = 1'b1;
        sample_ptr = 8'($urandom);
        over_from = c0 + 101;
        ss_model = (ss_model < 256) ? ss_model + 1 : 256;
        @(negedge sclk);
        sample_valid = 1'b0;
        wait_done(400);
        repeat (300) @(negedge sclk);
        check("overrun_set", overrun, 1);
        check("overrun_ov_count", ov_cnt, 1);
        check("overrun_ov_cycle", ov_cyc - c0, 194);

        // clear mid-frame
        set_rj_all(20);
        start_frame(8'h99, len);
        wait_rel(200);
        clear = 1'b1;
        erase(c0 + 201, c0 + len);
        ss_model = 0;
        @(negedge sclk);
        clear = 1'b0;
        check("clear_busy", busy, 0);
        check("clear_cmds", {alu_op, alu_shift, alu_clr, coef_rd_addr}, 0);
        repeat (400) @(negedge sclk);
        check("clear_no_ov", ov_cnt, 0);

        // first sample after clear
        set_rj_all(0);
        rj_mem[0] = 16'd3;
        coef_mem[0] = 16'h0100;
        coef_mem[1] = 16'h0001;
        coef_mem[2] = 16'h0005;
        start_frame(8'h40, len);
        wait_done(200);
        check("post_clear_ops", op_cnt, 3);
        if (op_q.size() >= 3) begin
            check("post_clear_op0", op_q[0], 2'd2);
            check("post_clear_dz0", dz_q[0], 0);
            check("post_clear_dz1", dz_q[1], ZF);
            check("post_clear_dz2", dz_q[2], ZF);
        end

        repeat (5) @(negedge sclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
